// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port registered-read RAM.
// After reset the whole RAM is zeroed (CLEAR), then requests are granted
// one per cycle with round-robin tie breaking (RUN).
module ram_arbiter #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic [SIZE-1:0] req0_wdata,
    input  logic            req0_we,
    output logic            rsp0_valid,
    output logic [SIZE-1:0] rsp0_rdata,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic [SIZE-1:0] req1_wdata,
    input  logic            req1_we,
    output logic            rsp1_valid,
    output logic [SIZE-1:0] rsp1_rdata,

    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data,

    output logic            busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            last_q;       // 1: requester 1 was granted most recently
    logic            rsp0_pend_q;
    logic            rsp1_pend_q;
    logic            busy_q;

    logic            run;
    logic            gnt0;
    logic            gnt1;

    // Grants are masked while rst is high so reset overrides any activity
    // in the same cycle, not just from the next edge onward.
    assign run  = (state_q == RUN) && !rst;
    assign gnt0 = run && req0_valid && (!req1_valid ||  last_q);
    assign gnt1 = run && req1_valid && (!req0_valid || !last_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = busy_q;

    // A pending read response is dropped as soon as rst is seen.
    assign rsp0_valid = rsp0_pend_q && !rst;
    assign rsp1_valid = rsp1_pend_q && !rst;
    assign rsp0_rdata = rsp0_valid ? ram_read_data : '0;
    assign rsp1_rdata = rsp1_valid ? ram_read_data : '0;

    // RAM port mux: clear sweep, granted requester, or idle zeros.
    always_comb begin
        ram_address    = '0;
        ram_write_data = '0;
        ram_write_en   = 1'b0;
        if (state_q == CLEAR) begin
            ram_address  = clr_cnt_q;
            ram_write_en = 1'b1;
        end else if (gnt0) begin
            ram_address    = req0_addr;
            ram_write_data = req0_wdata;
            ram_write_en   = req0_we;
        end else if (gnt1) begin
            ram_address    = req1_addr;
            ram_write_data = req1_wdata;
            ram_write_en   = req1_we;
        end
    end

    // Control FSM: clear sweep, round-robin pointer and read-response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            last_q      <= 1'b1;
            rsp0_pend_q <= 1'b0;
            rsp1_pend_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            rsp0_pend_q <= gnt0 && !req0_we;
            rsp1_pend_q <= gnt1 && !req1_we;
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (gnt0) begin
                        last_q <= 1'b0;
                    end else if (gnt1) begin
                        last_q <= 1'b1;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (SIZE=8, DEPTH=16) with a registered-read RAM.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_addr, req1_addr;
    logic [7:0] req0_wdata, req1_wdata;
    logic       req0_we, req1_we;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic [3:0] ram_address;
    logic [7:0] ram_write_data;
    logic       ram_write_en;
    logic [7:0] ram_read_data;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Expected read-response state for the next cycle, and expected RAM contents.
    logic       exp_rv0, exp_rv1;
    logic [7:0] exp_rd0, exp_rd1;
    logic [7:0] ref_mem [16];

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_arbiter #(.SIZE(8), .DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_we        (req0_we),
        .rsp0_valid     (rsp0_valid),
        .rsp0_rdata     (rsp0_rdata),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_we        (req1_we),
        .rsp1_valid     (rsp1_valid),
        .rsp1_rdata     (rsp1_rdata),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_write_en   (ram_write_en),
        .ram_read_data  (ram_read_data),
        .busy           (busy)
    );

    // Single-port RAM, read data registered one cycle after the address.
    always @(posedge clk) begin
        ram_read_data <= mem[ram_address];
        if (ram_write_en) mem[ram_address] <= ram_write_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_expect();
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        for (int unsigned i = 0; i < 16; i++) ref_mem[i] = '0;
    endtask

    // Checks the 16-cycle clear sweep; caller has just released rst and waited #1.
    task automatic clear_seq();
        for (int unsigned k = 0; k < 16; k++) begin
            if (k != 0) begin
                @(negedge clk);
                #1;
            end
            check("clr_busy",  32'(busy), 32'd1);
            check("clr_we",    32'(ram_write_en), 32'd1);
            check("clr_addr",  32'(ram_address), k);
            check("clr_wdata", 32'(ram_write_data), 32'd0);
            check("clr_ready0", 32'(req0_ready), 32'd0);
            check("clr_ready1", 32'(req1_ready), 32'd0);
        end
    endtask

    // One RUN cycle: drive both requesters, check hand-specified grants,
    // the RAM bus and the response from the previous cycle.
    task automatic cyc(input logic v0, input logic [3:0] a0, input logic [7:0] d0, input logic w0,
                       input logic v1, input logic [3:0] a1, input logic [7:0] d1, input logic w1,
                       input logic eg0, input logic eg1);
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_wdata = d0; req0_we = w0;
        req1_valid = v1; req1_addr = a1; req1_wdata = d1; req1_we = w1;
        #1;
        check("busy",   32'(busy), 32'd0);
        check("ready0", 32'(req0_ready), 32'(eg0));
        check("ready1", 32'(req1_ready), 32'(eg1));
        check("rsp0_valid", 32'(rsp0_valid), 32'(exp_rv0));
        check("rsp0_rdata", 32'(rsp0_rdata), exp_rv0 ? 32'(exp_rd0) : 32'd0);
        check("rsp1_valid", 32'(rsp1_valid), 32'(exp_rv1));
        check("rsp1_rdata", 32'(rsp1_rdata), exp_rv1 ? 32'(exp_rd1) : 32'd0);
        if (eg0) begin
            check("ram_addr",  32'(ram_address), 32'(a0));
            check("ram_we",    32'(ram_write_en), 32'(w0));
            check("ram_wdata", 32'(ram_write_data), 32'(d0));
        end else if (eg1) begin
            check("ram_addr",  32'(ram_address), 32'(a1));
            check("ram_we",    32'(ram_write_en), 32'(w1));
            check("ram_wdata", 32'(ram_write_data), 32'(d1));
        end else begin
            check("idle_addr",  32'(ram_address), 32'd0);
            check("idle_we",    32'(ram_write_en), 32'd0);
            check("idle_wdata", 32'(ram_write_data), 32'd0);
        end
        exp_rv0 = eg0 && !w0;
        exp_rv1 = eg1 && !w1;
        exp_rd0 = ref_mem[a0];
        exp_rd1 = ref_mem[a1];
        if (eg0 && w0) ref_mem[a0] = d0;
        if (eg1 && w1) ref_mem[a1] = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_we = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_we = 1'b0;
        clear_expect();

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  32'(busy), 32'd1);
        check("rst_rsp0",  32'(rsp0_valid), 32'd0);
        check("rst_rsp1",  32'(rsp1_valid), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);

        // Release reset with req0 already waiting to read address 5.
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd5; req0_we = 1'b0;
        #1;
        clear_seq();

        cyc(1, 4'd5, 8'h00, 0,  0, 4'd0, 8'h00, 0,  1, 0);   // first RUN cycle: granted
        cyc(1, 4'd3, 8'hA5, 1,  0, 4'd0, 8'h00, 0,  1, 0);   // write 3 <- A5
        cyc(1, 4'd3, 8'h00, 0,  0, 4'd0, 8'h00, 0,  1, 0);   // read 3 right after the write
        cyc(0, 4'd0, 8'h00, 0,  0, 4'd0, 8'h00, 0,  0, 0);   // idle, expect A5
        cyc(0, 4'd0, 8'h00, 0,  1, 4'd7, 8'h3C, 1,  0, 1);   // req1 write 7 <- 3C
        for (int unsigned i = 0; i < 4; i++)
            cyc(0, 4'd0, 8'h00, 0,  1, 4'(i), 8'h00, 0,  0, 1);
        for (int unsigned i = 0; i < 6; i++)
            cyc(1, 4'd3, 8'h00, 0,  1, 4'd7, 8'h00, 0,  (i % 2) == 0, (i % 2) == 1);
        cyc(0, 4'd0, 8'h00, 0,  0, 4'd0, 8'h00, 0,  0, 0);

        // Reset with a read response pending.
        cyc(1, 4'd3, 8'h00, 0,  0, 4'd0, 8'h00, 0,  1, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstpend_rsp0",  32'(rsp0_valid), 32'd0);
        check("rstpend_data0", 32'(rsp0_rdata), 32'd0);
        @(negedge clk);
        #1;
        check("rstpend_rsp0_next", 32'(rsp0_valid), 32'd0);
        check("rstpend_busy",      32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        clear_seq();
        clear_expect();

        // Pointer restored: req0 wins the first tie; memory really cleared.
        cyc(1, 4'd3, 8'h00, 0,  1, 4'd7, 8'h00, 0,  1, 0);
        cyc(1, 4'd3, 8'h00, 0,  1, 4'd7, 8'h00, 0,  0, 1);
        cyc(0, 4'd0, 8'h00, 0,  0, 4'd0, 8'h00, 0,  0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
